pipeline_hazard_unit: RTL and testbench

Parametrised hazard and forwarding controller for the five-stage MIPS pipeline. It tracks the destination registers of in-flight instructions in an internal tag pipeline, stalls decode on load-use hazards, flushes younger stages on a taken redirect, and generates registered forwarding selects for the EX-stage operand muxes. It sits beside the ID stage and drives the PC/IF_ID hold, the IF_ID/ID_EX flush, and the ALU operand forwarding muxes.

---
 rtl/pipeline_hazard_unit.sv | 159 +++++++++++++++
 tb/tb_pipeline_hazard_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_unit.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_unit
//
// Hazard and forwarding controller for a five-stage MIPS pipeline. It keeps a
// small tag pipeline with one entry per post-ID stage. Each entry records the
// destination register of an in-flight instruction and whether it is a load.
// From these tags the block does four things:
//   - stalls decode on a load-use hazard,
//   - flushes IF_ID and ID_EX on a taken redirect,
//   - reports whether the ID instruction issues on this edge,
//   - registers the EX-stage operand forwarding selects.
//
// Optional build macro: HAZARD_PERF_COUNTERS_EN adds stall/flush counters.
//
// Parameters
//   REG_ADDR_W : register address width
//   DEPTH      : post-ID stages not yet readable from the register file (1..7)
//   LOAD_LAT   : stages after EX before load data can be forwarded (0..DEPTH-1)
//   FWD_W      : forwarding select width (derived)
//
// Ports
//   clk, reset            : clock, synchronous active-low reset
//   id_valid              : valid instruction in ID
//   id_rs, id_rt          : ID source registers
//   id_uses_rs/_rt        : the ID instruction really reads rs / rt
//   id_dest               : ID destination register (after RegDst/Jal)
//   id_reg_write          : the ID instruction writes id_dest
//   id_mem_read           : the ID instruction is a load
//   branch_taken          : the EX instruction redirects the PC
//   stall                 : hold PC/IF_ID and bubble ID_EX
//   issue                 : the ID instruction advances into EX on this edge
//   flush_if_id/_id_ex    : clear the pipeline registers on this edge
//   fwd_a_sel, fwd_b_sel  : operand source for the instruction in EX
//                           (0 = regfile, k = result held k stages ahead)
//   stall_count, flush_count (macro only) : wrapping event counters
// -----------------------------------------------------------------------------
module pipeline_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_LAT   = 1,
  localparam int FWD_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  branch_taken,
  output logic                  stall,
  output logic                  issue,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic [FWD_W-1:0]      fwd_a_sel,
  output logic [FWD_W-1:0]      fwd_b_sel
`ifdef HAZARD_PERF_COUNTERS_EN
  ,
  output logic [31:0]           stall_count,
  output logic [31:0]           flush_count
`endif
);

  // Tag pipeline: entry 0 is the instruction in EX, entry k is k stages beyond.
  logic                  tag_valid_q [DEPTH];
  logic [REG_ADDR_W-1:0] tag_dest_q  [DEPTH];
  logic                  tag_load_q  [DEPTH];
  logic                  tag_valid_d [DEPTH];
  logic [REG_ADDR_W-1:0] tag_dest_d  [DEPTH];
  logic                  tag_load_d  [DEPTH];

  logic [FWD_W-1:0] sel_a_d, sel_b_d;
  logic [FWD_W-1:0] fwd_a_sel_q, fwd_b_sel_q;
  logic             hit_load_a, hit_load_b;

  // Youngest-match search. Scanning from the oldest entry down to entry 0 lets
  // the lowest matching k overwrite any older match.
  always_comb begin
    sel_a_d    = '0;
    sel_b_d    = '0;
    hit_load_a = 1'b0;
    hit_load_b = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (id_uses_rs && (id_rs != '0) && tag_valid_q[k] && (tag_dest_q[k] == id_rs)) begin
        sel_a_d    = FWD_W'(k + 1);
        hit_load_a = tag_load_q[k] && ((k + 1) <= LOAD_LAT);
      end
      if (id_uses_rt && (id_rt != '0) && tag_valid_q[k] && (tag_dest_q[k] == id_rt)) begin
        sel_b_d    = FWD_W'(k + 1);
        hit_load_b = tag_load_q[k] && ((k + 1) <= LOAD_LAT);
      end
    end
  end

  // A redirect kills the ID instruction anyway, so it suppresses the stall.
  assign stall       = id_valid & ~branch_taken & (hit_load_a | hit_load_b);
  assign issue       = id_valid & ~stall & ~branch_taken;
  assign flush_if_id = branch_taken;
  assign flush_id_ex = branch_taken;

  // Entry 0 takes the issuing instruction. It becomes a bubble on a stall or a
  // flush. It is also a bubble if the instruction never writes a usable
  // register, because $0 must never match.
  assign tag_valid_d[0] = issue & id_reg_write & (id_dest != '0);
  assign tag_dest_d[0]  = id_dest;
  assign tag_load_d[0]  = id_mem_read;

  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_shift
    assign tag_valid_d[gi] = tag_valid_q[gi-1];
    assign tag_dest_d[gi]  = tag_dest_q[gi-1];
    assign tag_load_d[gi]  = tag_load_q[gi-1];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        tag_valid_q[k] <= 1'b0;
        tag_dest_q[k]  <= '0;
        tag_load_q[k]  <= 1'b0;
      end
      fwd_a_sel_q <= '0;
      fwd_b_sel_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        tag_valid_q[k] <= tag_valid_d[k];
        tag_dest_q[k]  <= tag_dest_d[k];
        tag_load_q[k]  <= tag_load_d[k];
      end
      // The selects belong to the instruction entering EX. A bubble gets 0.
      fwd_a_sel_q <= issue ? sel_a_d : '0;
      fwd_b_sel_q <= issue ? sel_b_d : '0;
    end
  end

  assign fwd_a_sel = fwd_a_sel_q;
  assign fwd_b_sel = fwd_b_sel_q;

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] stall_count_q, flush_count_q;

  // The counters wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      if (stall)        stall_count_q <= stall_count_q + 32'd1;
      if (branch_taken) flush_count_q <= flush_count_q + 32'd1;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_unit
//
// Directed test of pipeline_hazard_unit with its default parameters.
// The stimulus process drives one vector per cycle just after the rising edge.
// For that same cycle it queues the hand-computed expected outputs.
// The monitor process pops one entry at each falling edge and compares it
// against the DUT. Each queued entry holds:
//   - the combinational stall/issue/flush values,
//   - the fwd selects registered at the previous edge,
//   - optionally, the performance counter values.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_unit;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, branch_taken;
  logic       stall, issue, flush_if_id, flush_id_ex;
  logic [1:0] fwd_a_sel, fwd_b_sel;
`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] stall_count, flush_count;
`endif

  pipeline_hazard_unit dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_dest      (id_dest),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .branch_taken (branch_taken),
    .stall        (stall),
    .issue        (issue),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel)
`ifdef HAZARD_PERF_COUNTERS_EN
    ,
    .stall_count  (stall_count),
    .flush_count  (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       e_stall;
    logic       e_issue;
    logic       e_flush;
    logic [1:0] e_fa;
    logic [1:0] e_fb;
    bit         chk_fwd;
    bit         chk_cnt;
    int         e_sc;
    int         e_fc;
  } exp_t;

  exp_t sb[$];
  int   vectors    = 0;
  int   miscompares = 0;
  bit   stim_done  = 1'b0;

  // Generic vector: drive for one cycle and queue its expectation.
  task automatic vec(input string nm, input logic rst, input logic v,
                     input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt,
                     input logic [4:0] dst, input logic rw, input logic mr,
                     input logic bt, input logic e_stall, input logic e_issue,
                     input logic [1:0] e_fa, input logic [1:0] e_fb,
                     input bit chk_fwd, input bit chk_cnt,
                     input int e_sc, input int e_fc);
    exp_t r;
    @(posedge clk);
    #1;
    reset        = rst;
    id_valid     = v;
    id_rs        = rs;
    id_rt        = rt;
    id_uses_rs   = urs;
    id_uses_rt   = urt;
    id_dest      = dst;
    id_reg_write = rw;
    id_mem_read  = mr;
    branch_taken = bt;
    r.name    = nm;
    r.e_stall = e_stall;
    r.e_issue = e_issue;
    r.e_flush = bt;
    r.e_fa    = e_fa;
    r.e_fb    = e_fb;
    r.chk_fwd = chk_fwd;
    r.chk_cnt = chk_cnt;
    r.e_sc    = e_sc;
    r.e_fc    = e_fc;
    sb.push_back(r);
  endtask

  // Valid instruction, out of reset, forwarding checked.
  task automatic op(input string nm, input logic [4:0] rs, input logic [4:0] rt,
                    input logic urs, input logic urt, input logic [4:0] dst,
                    input logic rw, input logic mr, input logic bt,
                    input logic e_stall, input logic e_issue,
                    input logic [1:0] e_fa, input logic [1:0] e_fb);
    vec(nm, 1'b1, 1'b1, rs, rt, urs, urt, dst, rw, mr, bt, e_stall, e_issue,
        e_fa, e_fb, 1'b1, 1'b0, 0, 0);
  endtask

  // Empty ID slot.
  task automatic idle(input string nm, input logic bt,
                      input logic [1:0] e_fa, input logic [1:0] e_fb);
    vec(nm, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, bt,
        1'b0, 1'b0, e_fa, e_fb, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic chk(input string nm, input string f, input int got, input int want);
    if (got != want) begin
      miscompares++;
      $display("FAIL %s.%s got %0d expected %0d", nm, f, got, want);
    end
  endtask

  // Monitor: one queued expectation per cycle, compared mid-cycle.
  initial begin
    exp_t r;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        r = sb.pop_front();
        vectors++;
        $display("vec %0d %-16s stall=%0d issue=%0d flush=%0d/%0d fa=%0d fb=%0d",
                 vectors, r.name, stall, issue, flush_if_id, flush_id_ex,
                 fwd_a_sel, fwd_b_sel);
        chk(r.name, "stall", int'(stall), int'(r.e_stall));
        chk(r.name, "issue", int'(issue), int'(r.e_issue));
        chk(r.name, "flush_if_id", int'(flush_if_id), int'(r.e_flush));
        chk(r.name, "flush_id_ex", int'(flush_id_ex), int'(r.e_flush));
        if (r.chk_fwd) begin
          chk(r.name, "fwd_a_sel", int'(fwd_a_sel), int'(r.e_fa));
          chk(r.name, "fwd_b_sel", int'(fwd_b_sel), int'(r.e_fb));
        end
`ifdef HAZARD_PERF_COUNTERS_EN
        if (r.chk_cnt) begin
          chk(r.name, "stall_count", int'(stall_count), r.e_sc);
          chk(r.name, "flush_count", int'(flush_count), r.e_fc);
        end
`endif
      end
    end
  end

  // Stimulus.
  initial begin
    reset = 1'b0; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_dest = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_reg_write = 1'b0;
    id_mem_read = 1'b0; branch_taken = 1'b0;

    // Reset: registers unknown in the first cycle, cleared afterwards.
    vec("rst0", 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 0, 0);
    vec("rst1_br", 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1,
        1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 0, 0);

    // add $8 then add $9,$8,$8: forward from EX/MEM on both operands.
    op("add8",      5'd1, 5'd2, 1, 1, 5'd8,  1, 0, 0, 0, 1, 2'd0, 2'd0);
    op("add9_8_8",  5'd8, 5'd8, 1, 1, 5'd9,  1, 0, 0, 0, 1, 2'd0, 2'd0);
    idle("ex_add9", 1'b0, 2'd1, 2'd1);

    // lw $9 then add $10,$9,$0: one stall, then forward from MEM/WB.
    op("lw9",       5'd1, 5'd0, 1, 0, 5'd9,  1, 1, 0, 0, 1, 2'd0, 2'd0);
    op("add10_stl", 5'd9, 5'd0, 1, 1, 5'd10, 1, 0, 0, 1, 0, 2'd0, 2'd0);
    op("add10_iss", 5'd9, 5'd0, 1, 1, 5'd10, 1, 0, 0, 0, 1, 2'd0, 2'd0);
    idle("ex_add10", 1'b0, 2'd2, 2'd0);

    // Producer three instructions ahead -> select 3.
    op("add8b",     5'd1, 5'd2, 1, 1, 5'd8,  1, 0, 0, 0, 1, 2'd0, 2'd0);
    op("nop1",      5'd0, 5'd0, 0, 0, 5'd0,  0, 0, 0, 0, 1, 2'd0, 2'd0);
    op("nop2",      5'd0, 5'd0, 0, 0, 5'd0,  0, 0, 0, 0, 1, 2'd0, 2'd0);
    op("use8_d3",   5'd8, 5'd3, 1, 0, 5'd11, 1, 0, 0, 0, 1, 2'd0, 2'd0);
    // Producer four instructions ahead -> regfile (select 0).
    op("add8c",     5'd1, 5'd2, 1, 1, 5'd8,  1, 0, 0, 0, 1, 2'd3, 2'd0);
    op("nop3",      5'd0, 5'd0, 0, 0, 5'd0,  0, 0, 0, 0, 1, 2'd0, 2'd0);
    op("nop4",      5'd0, 5'd0, 0, 0, 5'd0,  0, 0, 0, 0, 1, 2'd0, 2'd0);
    op("nop5",      5'd0, 5'd0, 0, 0, 5'd0,  0, 0, 0, 0, 1, 2'd0, 2'd0);
    op("use8_d4",   5'd8, 5'd0, 1, 0, 5'd12, 1, 0, 0, 0, 1, 2'd0, 2'd0);
    idle("ex_use8d4", 1'b0, 2'd0, 2'd0);

    // Load into $0, then read $0: no stall, no forwarding.
    op("lw0",       5'd1, 5'd2, 1, 1, 5'd0,  1, 1, 0, 0, 1, 2'd0, 2'd0);
    op("use0",      5'd0, 5'd0, 1, 1, 5'd13, 1, 0, 0, 0, 1, 2'd0, 2'd0);
    idle("ex_use0", 1'b0, 2'd0, 2'd0);

    // lw $9 then a use of $9 under a redirect: flush wins and entry 0 is a
    // bubble. A later reader of $10 finds no match, and $9 comes from MEM/WB.
    op("lw9b",      5'd1, 5'd0, 1, 0, 5'd9,  1, 1, 0, 0, 1, 2'd0, 2'd0);
    op("use9_br",   5'd9, 5'd0, 1, 0, 5'd10, 1, 0, 1, 0, 0, 2'd0, 2'd0);
    op("rd10_9",    5'd10, 5'd9, 1, 1, 5'd14, 1, 0, 0, 0, 1, 2'd0, 2'd0);
    idle("ex_rd10_9", 1'b0, 2'd0, 2'd2);

    // Reset during a load-use stall: the stall and the tags vanish.
    op("lw9c",      5'd1, 5'd0, 1, 0, 5'd9,  1, 1, 0, 0, 1, 2'd0, 2'd0);
    vec("use9_rst", 1'b0, 1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0,
        1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 0, 0);
    op("use9_post", 5'd9, 5'd9, 1, 1, 5'd10, 1, 0, 0, 0, 1, 2'd0, 2'd0);
    vec("ex_post_rst", 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 0, 0);

    // Five load-use stalls, then two redirects.
    for (int i = 0; i < 5; i++) begin
      op("lw9_loop",  5'd1, 5'd0, 1, 0, 5'd9,  1, 1, 0, 0, 1,
         (i == 0) ? 2'd0 : 2'd2, (i == 0) ? 2'd0 : 2'd2);
      op("use9_stl",  5'd9, 5'd9, 1, 1, 5'd10, 1, 0, 0, 1, 0, 2'd0, 2'd0);
      op("use9_iss",  5'd9, 5'd9, 1, 1, 5'd10, 1, 0, 0, 0, 1, 2'd0, 2'd0);
    end
    idle("flush1", 1'b1, 2'd2, 2'd2);
    idle("flush2", 1'b1, 2'd0, 2'd0);
    vec("counters", 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 5, 2);

    @(posedge clk);
    #1;
    id_valid = 1'b0;
    branch_taken = 1'b0;
    stim_done = 1'b1;
  end

  // End of test: drain the scoreboard with a bounded wait.
  initial begin
    wait (stim_done);
    for (int n = 0; n < 10 && sb.size() > 0; n++) @(negedge clk);
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
